// File: rtl/light_uart_port_if.sv
// rtl/light_uart_port_if.sv - host-side TX/RX byte stream bundle of one UART port.
// master = host (pushes TX bytes, pops RX entries); slave = the UART port.
interface light_uart_port_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_perr, rx_ferr, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_perr, rx_ferr, rx_valid
  );
endinterface

// File: rtl/light_uart_port.sv
// rtl/light_uart_port.sv - UART port with TX/RX FIFOs, runtime divisor and configurable frame.
// Optional CTS/RTS flow control is built when LIGHT_UART_PORT_FLOWCTL_EN is defined.
module light_uart_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module light_uart_port #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_LEVEL  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  light_uart_port_if.slave      host,
  input  logic [31:0]           dbr,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic                  rx_overrun,
  output logic                  tx_busy,
  input  logic                  rxd,
  input  logic                  cts,
  output logic                  txd,
  output logic                  rts
);
  localparam int BW = $clog2(DATA_BITS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

  logic [35:0] p_cur;
  assign p_cur = {(dbr == 32'd0) ? 32'd1 : dbr, 4'b0000};

  // FIFOs
  logic                 tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic [LW-1:0]        tx_level;
  logic                 rx_push, rx_full, rx_empty, rx_do_pop;
  logic [DATA_BITS+1:0] rx_push_data, rx_head;
  logic [LW-1:0]        rx_level;

  light_uart_port_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(host.tx_valid && host.tx_ready), .push_data(host.tx_data),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  light_uart_port_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .push_data(rx_push_data),
    .pop(host.rx_ready), .head(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign host.tx_ready = !tx_full;
  assign host.rx_valid = !rx_empty;
  assign host.rx_data  = rx_head[DATA_BITS-1:0];
  assign host.rx_ferr  = rx_head[DATA_BITS];
  assign host.rx_perr  = rx_head[DATA_BITS+1];
  assign rx_do_pop     = host.rx_ready && !rx_empty;

  logic unused_tx_level;
  assign unused_tx_level = ^tx_level;

  // Flow control
  logic cts_ok;
  logic rx_high;
  assign rx_high = int'(rx_level) >= RTS_LEVEL;
`ifdef LIGHT_UART_PORT_FLOWCTL_EN
  logic cts_s1, cts_s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= cts;
      cts_s2 <= cts_s1;
    end
  end
  assign cts_ok = !cts_s2;
  assign rts    = rx_high;
`else
  logic unused_flow;
  assign unused_flow = cts ^ rx_high;
  assign cts_ok      = 1'b1;
  assign rts         = 1'b0;
`endif

  // TX FSM
  uart_state_t          tx_state, tx_state_n;
  logic [35:0]          tx_cnt, tx_cnt_n, tx_p, tx_p_n;
  logic [BW-1:0]        tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par_en, tx_par_en_n, tx_par_bit, tx_par_bit_n, tx_stop, tx_stop_n;
  logic                 tx_bit_end, tx_load;

  assign tx_bit_end = (tx_cnt == tx_p - 36'd1);
  assign tx_busy    = (tx_state != S_IDLE) || !tx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= S_IDLE;
      tx_cnt     <= '0;
      tx_p       <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop    <= 1'b0;
    end else begin
      tx_state   <= tx_state_n;
      tx_cnt     <= tx_cnt_n;
      tx_p       <= tx_p_n;
      tx_bit     <= tx_bit_n;
      tx_sh      <= tx_sh_n;
      tx_par_en  <= tx_par_en_n;
      tx_par_bit <= tx_par_bit_n;
      tx_stop    <= tx_stop_n;
    end
  end

  always_comb begin
    tx_state_n   = tx_state;
    tx_cnt_n     = tx_cnt + 36'd1;
    tx_p_n       = tx_p;
    tx_bit_n     = tx_bit;
    tx_sh_n      = tx_sh;
    tx_par_en_n  = tx_par_en;
    tx_par_bit_n = tx_par_bit;
    tx_stop_n    = tx_stop;
    tx_load      = 1'b0;
    tx_pop       = 1'b0;
    txd          = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        tx_load  = !tx_empty && cts_ok;
      end
      S_START: begin
        txd = 1'b0;
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = S_DATA;
        end
      end
      S_DATA: begin
        txd = tx_sh[0];
        if (tx_bit_end) begin
          tx_cnt_n = '0;
          tx_sh_n  = tx_sh >> 1;
          if (tx_bit == BW'(DATA_BITS-1)) begin
            tx_stop_n  = 1'b0;
            tx_state_n = tx_par_en ? S_PARITY : S_STOP;
          end else begin
            tx_bit_n = tx_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        txd = tx_par_bit;
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_stop_n  = 1'b0;
          tx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_n = '0;
          if ((STOP_BITS == 1) || tx_stop) begin
            // Chain straight into the next start bit so queued frames have no idle gap.
            tx_load    = !tx_empty && cts_ok;
            tx_state_n = S_IDLE;
          end else begin
            tx_stop_n = 1'b1;
          end
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
    if (tx_load) begin
      tx_state_n   = S_START;
      tx_cnt_n     = '0;
      tx_pop       = 1'b1;
      tx_sh_n      = tx_head;
      tx_p_n       = p_cur;
      tx_par_en_n  = parity_en;
      tx_par_bit_n = (^tx_head) ^ parity_odd;
    end
  end

  // RX FSM
  uart_state_t          rx_state, rx_state_n;
  logic                 rxd_s1, rxd_s2, rxd_s3;
  logic [35:0]          rx_cnt, rx_cnt_n, rx_p, rx_p_n;
  logic [BW-1:0]        rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_par_en, rx_par_en_n, rx_par_odd, rx_par_odd_n, rx_perr, rx_perr_n;
  logic                 rx_bit_end, rx_ferr;

  assign rx_bit_end   = (rx_cnt == rx_p - 36'd1);
  assign rx_push_data = {rx_perr, rx_ferr, rx_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1     <= 1'b1;
      rxd_s2     <= 1'b1;
      rxd_s3     <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_p       <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_perr    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rxd_s1     <= rxd;
      rxd_s2     <= rxd_s1;
      rxd_s3     <= rxd_s2;
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_p       <= rx_p_n;
      rx_bit     <= rx_bit_n;
      rx_sh      <= rx_sh_n;
      rx_par_en  <= rx_par_en_n;
      rx_par_odd <= rx_par_odd_n;
      rx_perr    <= rx_perr_n;
      rx_overrun <= rx_push && rx_full && !rx_do_pop;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt + 36'd1;
    rx_p_n       = rx_p;
    rx_bit_n     = rx_bit;
    rx_sh_n      = rx_sh;
    rx_par_en_n  = rx_par_en;
    rx_par_odd_n = rx_par_odd;
    rx_perr_n    = rx_perr;
    rx_push      = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rxd_s3 && !rxd_s2) begin
          rx_state_n   = S_START;
          rx_p_n       = p_cur;
          rx_par_en_n  = parity_en;
          rx_par_odd_n = parity_odd;
          rx_perr_n    = 1'b0;
        end
      end
      S_START: begin
        // Half a period in: a high line here was a glitch, not a start bit.
        if (rx_cnt == {1'b0, rx_p[35:1]} - 36'd1) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rxd_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rxd_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == BW'(DATA_BITS-1)) rx_state_n = rx_par_en ? S_PARITY : S_STOP;
          else                            rx_bit_n   = rx_bit + 1'b1;
        end
      end
      S_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_n   = '0;
          rx_perr_n  = rxd_s2 ^ (^rx_sh) ^ rx_par_odd;
          rx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_ferr    = !rxd_s2;
          rx_push    = 1'b1;
          rx_state_n = S_IDLE;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end
endmodule
